// File: rtl/irq_seq_pkg.sv
// irq_seq_pkg: shared types and constants for the 65C02 interrupt sequencer.
//   - state_t / ST_* : sequencer state encoding (ST_WAIT only when WAI_SUPPORT_EN)
//   - SRC_PCH..SRC_NONE : stack_src output encoding
//   - irq_src_e : which event owns the current sequence
//   - VEC_LO_* : low byte of each vector address (FFFA/FFFC/FFFE)
package irq_seq_pkg;

   typedef logic [3:0] state_t;

   localparam state_t ST_IDLE     = 4'd0;
   localparam state_t ST_RST_HOLD = 4'd1;
   localparam state_t ST_RST_D1   = 4'd2;
   localparam state_t ST_RST_D2   = 4'd3;
   localparam state_t ST_RST_D3   = 4'd4;
   localparam state_t ST_PUSH_PCH = 4'd5;
   localparam state_t ST_PUSH_PCL = 4'd6;
   localparam state_t ST_PUSH_P   = 4'd7;
   localparam state_t ST_VEC_LO   = 4'd8;
   localparam state_t ST_VEC_HI   = 4'd9;
   localparam state_t ST_LOAD     = 4'd10;
`ifdef WAI_SUPPORT_EN
   localparam state_t ST_WAIT     = 4'd11;
`endif

   localparam logic [1:0] SRC_PCH  = 2'd0;
   localparam logic [1:0] SRC_PCL  = 2'd1;
   localparam logic [1:0] SRC_P    = 2'd2;
   localparam logic [1:0] SRC_NONE = 2'd3;

   typedef enum logic [1:0] {
      SRC_RST = 2'd0,
      SRC_NMI = 2'd1,
      SRC_IRQ = 2'd2,
      SRC_BRK = 2'd3
   } irq_src_e;

   localparam logic [7:0] VEC_LO_NMI = 8'hFA;
   localparam logic [7:0] VEC_LO_RES = 8'hFC;
   localparam logic [7:0] VEC_LO_IRQ = 8'hFE;

endpackage

// File: rtl/irq_sequencer_nmi_edge_latch.sv
// nmi_edge_latch: falling-edge detector on the synchronised NMIB pin plus a
// pending latch. Capture runs every clock regardless of rdy so that an NMI
// edge is never lost while the core is stalled.
//   clk     : core clock
//   reset   : asynchronous active-high reset
//   nmib_n  : synchronised NMIB pin
//   clear   : consume the pending NMI (a simultaneous new edge wins)
//   pending : an NMI edge has been seen and not yet consumed
module nmi_edge_latch (
   input  logic clk,
   input  logic reset,
   input  logic nmib_n,
   input  logic clear,
   output logic pending
);

   logic nmib_prev;
   logic fall;

   assign fall = nmib_prev & ~nmib_n;

   // The previous sample resets high so a pin held low through reset is not
   // mistaken for an edge.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         nmib_prev <= 1'b1;
         pending   <= 1'b0;
      end else begin
         nmib_prev <= nmib_n;
         pending   <= fall | (pending & ~clear);
      end
   end

endmodule

// File: rtl/irq_sequencer.sv
// irq_sequencer: sequences 65C02 reset, NMI, IRQ and BRK entry for the
// PC/stack datapath. Pending sources are arbitrated at instruction
// boundaries, then three stack pushes (dummy reads for reset), the PCL
// vector select, the PCL increment for the high vector byte, and the final
// PC load are strobed one cycle each.
//
// Optional feature: define WAI_SUPPORT_EN to add the wai_decoded input and
// the WAIT state (wait for NMI/IRQ after a WAI opcode).
//
// Ports:
//   fclk, reset        : clock, asynchronous active-high reset
//   resb_n             : RESB pin (level, active low), overrides everything
//   nmib_n             : NMIB pin (falling edge)
//   irqb_n, i_flag     : IRQB pin (level, active low) and status I bit
//   brk_decoded        : current opcode is BRK
//   wai_decoded        : current opcode is WAI (WAI_SUPPORT_EN only)
//   instr_boundary     : last cycle of an instruction
//   rdy                : 0 freezes the sequencer
//   busy               : sequence in progress
//   stack_wr/stack_src : stack write strobe and pushed-byte select
//   b_flag             : B bit of the pushed P
//   push_resb/nmib/irqb: PCL vector select (FC/FA/FE)
//   increment_pc       : PCL increment for the vector high byte
//   load_pc, set_i, clear_d : final vector load and flag updates
module irq_sequencer
   import irq_seq_pkg::*;
#(
   parameter int RESET_HOLD_MIN = 2
) (
   input  logic       fclk,
   input  logic       reset,
   input  logic       resb_n,
   input  logic       nmib_n,
   input  logic       irqb_n,
   input  logic       i_flag,
   input  logic       brk_decoded,
`ifdef WAI_SUPPORT_EN
   input  logic       wai_decoded,
`endif
   input  logic       instr_boundary,
   input  logic       rdy,
   output logic       busy,
   output logic       stack_wr,
   output logic [1:0] stack_src,
   output logic       b_flag,
   output logic       push_resb,
   output logic       push_nmib,
   output logic       push_irqb,
   output logic       increment_pc,
   output logic       load_pc,
   output logic       set_i,
   output logic       clear_d
);

   localparam int CNT_W = $clog2(RESET_HOLD_MIN + 1);
   localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(RESET_HOLD_MIN - 1);
   localparam logic [CNT_W-1:0] HOLD_SAT  = CNT_W'(RESET_HOLD_MIN);

   state_t           state, state_n;
   irq_src_e         src, src_n;
   logic [CNT_W-1:0] hold_cnt, hold_cnt_n;
   logic             nmi_pending;
   logic             nmi_clear;

   nmi_edge_latch u_nmi (
      .clk     (fclk),
      .reset   (reset),
      .nmib_n  (nmib_n),
      .clear   (nmi_clear),
      .pending (nmi_pending)
   );

   always_comb begin
      state_n    = state;
      src_n      = src;
      nmi_clear  = 1'b0;
      hold_cnt_n = hold_cnt;

      // hold_cnt = cycles already spent in RST_HOLD; a low RESB advances it
      // even while rdy is low because reset overrides the stall.
      if (state != ST_RST_HOLD)
         hold_cnt_n = '0;
      else if ((rdy || !resb_n) && (hold_cnt < HOLD_SAT))
         hold_cnt_n = hold_cnt + 1'b1;

      if (!resb_n) begin
         state_n = ST_RST_HOLD;
         src_n   = SRC_RST;
      end else if (rdy) begin
         case (state)
            ST_IDLE: begin
               if (instr_boundary) begin
                  if (nmi_pending) begin
                     state_n = ST_PUSH_PCH;
                     src_n   = SRC_NMI;
                  end else if (!irqb_n && !i_flag) begin
                     state_n = ST_PUSH_PCH;
                     src_n   = SRC_IRQ;
                  end else if (brk_decoded) begin
                     state_n = ST_PUSH_PCH;
                     src_n   = SRC_BRK;
                  end
`ifdef WAI_SUPPORT_EN
                  else if (wai_decoded) begin
                     state_n = ST_WAIT;
                  end
`endif
               end
            end
            ST_RST_HOLD: if (hold_cnt >= HOLD_LAST) state_n = ST_RST_D1;
            ST_RST_D1:   state_n = ST_RST_D2;
            ST_RST_D2:   state_n = ST_RST_D3;
            ST_RST_D3:   state_n = ST_VEC_LO;
            ST_PUSH_PCH: state_n = ST_PUSH_PCL;
            ST_PUSH_PCL: state_n = ST_PUSH_P;
            ST_PUSH_P: begin
               // A pending NMI hijacks the vector of an IRQ/BRK entry; the
               // already pushed B bit is unaffected.
               state_n = ST_VEC_LO;
               if (nmi_pending) begin
                  src_n     = SRC_NMI;
                  nmi_clear = 1'b1;
               end
            end
            ST_VEC_LO:   state_n = ST_VEC_HI;
            ST_VEC_HI:   state_n = ST_LOAD;
            ST_LOAD:     state_n = ST_IDLE;
`ifdef WAI_SUPPORT_EN
            ST_WAIT: begin
               if (nmi_pending) begin
                  state_n = ST_PUSH_PCH;
                  src_n   = SRC_NMI;
               end else if (!irqb_n) begin
                  // A masked IRQ only wakes the core; it is not serviced.
                  if (i_flag) begin
                     state_n = ST_IDLE;
                  end else begin
                     state_n = ST_PUSH_PCH;
                     src_n   = SRC_IRQ;
                  end
               end
            end
`endif
            default:     state_n = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge fclk or posedge reset) begin
      if (reset) begin
         state    <= ST_IDLE;
         src      <= SRC_RST;
         hold_cnt <= '0;
      end else begin
         state    <= state_n;
         src      <= src_n;
         hold_cnt <= hold_cnt_n;
      end
   end

   // Outputs decode straight from the state register so an asynchronous
   // reset drops every strobe immediately, including a stack write.
   always_comb begin
      busy         = (state != ST_IDLE);
      stack_wr     = 1'b0;
      stack_src    = SRC_NONE;
      b_flag       = 1'b0;
      push_resb    = 1'b0;
      push_nmib    = 1'b0;
      push_irqb    = 1'b0;
      increment_pc = 1'b0;
      load_pc      = 1'b0;
      set_i        = 1'b0;
      clear_d      = 1'b0;
      case (state)
         ST_PUSH_PCH: begin
            stack_wr  = 1'b1;
            stack_src = SRC_PCH;
         end
         ST_PUSH_PCL: begin
            stack_wr  = 1'b1;
            stack_src = SRC_PCL;
         end
         ST_PUSH_P: begin
            stack_wr  = 1'b1;
            stack_src = SRC_P;
            b_flag    = (src == SRC_BRK);
         end
         ST_VEC_LO: begin
            case (src)
               SRC_RST: push_resb = 1'b1;
               SRC_NMI: push_nmib = 1'b1;
               default: push_irqb = 1'b1;
            endcase
         end
         ST_VEC_HI: increment_pc = 1'b1;
         ST_LOAD: begin
            load_pc = 1'b1;
            set_i   = 1'b1;
            clear_d = 1'b1;
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_irq_sequencer.sv
// Bench for irq_sequencer: directed entry sequences followed by randomized
// pin activity, every cycle compared against a queue-based reference model.
// Output word layout: {busy, stack_wr, stack_src[1:0], b_flag, push_resb,
// push_nmib, push_irqb, increment_pc, load_pc, set_i, clear_d}.
module tb_irq_sequencer;
   import irq_seq_pkg::*;

   localparam int HOLD_MIN = 2;

   logic fclk = 1'b0;
   logic reset = 1'b1;
   logic resb_n = 1'b1;
   logic nmib_n = 1'b1;
   logic irqb_n = 1'b1;
   logic i_flag = 1'b1;
   logic brk_decoded = 1'b0;
   logic instr_boundary = 1'b0;
   logic rdy = 1'b1;
`ifdef WAI_SUPPORT_EN
   logic wai_decoded = 1'b0;
`endif

   logic       busy, stack_wr, b_flag, push_resb, push_nmib, push_irqb;
   logic       increment_pc, load_pc, set_i, clear_d;
   logic [1:0] stack_src;
   logic [11:0] obs;

   int tests = 0;
   int fails = 0;

   always #5 fclk = ~fclk;

   irq_sequencer #(.RESET_HOLD_MIN(HOLD_MIN)) dut (
      .fclk           (fclk),
      .reset          (reset),
      .resb_n         (resb_n),
      .nmib_n         (nmib_n),
      .irqb_n         (irqb_n),
      .i_flag         (i_flag),
      .brk_decoded    (brk_decoded),
`ifdef WAI_SUPPORT_EN
      .wai_decoded    (wai_decoded),
`endif
      .instr_boundary (instr_boundary),
      .rdy            (rdy),
      .busy           (busy),
      .stack_wr       (stack_wr),
      .stack_src      (stack_src),
      .b_flag         (b_flag),
      .push_resb      (push_resb),
      .push_nmib      (push_nmib),
      .push_irqb      (push_irqb),
      .increment_pc   (increment_pc),
      .load_pc        (load_pc),
      .set_i          (set_i),
      .clear_d        (clear_d)
   );

   assign obs = {busy, stack_wr, stack_src, b_flag, push_resb, push_nmib,
                 push_irqb, increment_pc, load_pc, set_i, clear_d};

   // ---------------- reference model ----------------
   // A sequence is a queue of remaining cycle kinds; the front is the
   // current cycle.
   typedef enum int {K_DUMMY, K_PCH, K_PCL, K_P, K_VEC, K_INC, K_LOAD} kind_e;
   typedef enum int {M_IDLE, M_HOLD, M_SEQ, M_WAIT} mode_e;

   kind_e      q[$];
   mode_e      mode;
   int         spent;
   bit         m_latch;
   bit         m_prev;
   irq_src_e   m_src;
   logic [7:0] m_vec;

   task automatic model_reset();
      mode    = M_IDLE;
      q.delete();
      spent   = 0;
      m_latch = 1'b0;
      m_prev  = 1'b1;
      m_src   = SRC_RST;
      m_vec   = VEC_LO_RES;
   endtask

   task automatic start_seq(input irq_src_e s);
      m_src = s;
      m_vec = (s == SRC_NMI) ? VEC_LO_NMI : VEC_LO_IRQ;
      q     = '{K_PCH, K_PCL, K_P, K_VEC, K_INC, K_LOAD};
      mode  = M_SEQ;
   endtask

   task automatic start_reset();
      m_src = SRC_RST;
      m_vec = VEC_LO_RES;
      q     = '{K_DUMMY, K_DUMMY, K_DUMMY, K_VEC, K_INC, K_LOAD};
      mode  = M_SEQ;
   endtask

   task automatic model_step();
      bit    fall, clr;
      kind_e k;
      fall   = m_prev & ~nmib_n;
      m_prev = nmib_n;
      clr    = 1'b0;
      if (!resb_n) begin
         if (mode != M_HOLD) spent = 0;
         else if (spent < HOLD_MIN) spent++;
         mode = M_HOLD;
         q.delete();
      end else if (rdy) begin
         case (mode)
            M_IDLE: if (instr_boundary) begin
               if (m_latch)                 start_seq(SRC_NMI);
               else if (!irqb_n && !i_flag) start_seq(SRC_IRQ);
               else if (brk_decoded)        start_seq(SRC_BRK);
`ifdef WAI_SUPPORT_EN
               else if (wai_decoded)        mode = M_WAIT;
`endif
            end
            M_HOLD: begin
               if (spent >= HOLD_MIN - 1) start_reset();
               else spent++;
            end
            M_WAIT: begin
               if (m_latch) start_seq(SRC_NMI);
               else if (!irqb_n) begin
                  if (i_flag) mode = M_IDLE;
                  else start_seq(SRC_IRQ);
               end
            end
            default: begin
               k = q.pop_front();
               if (k == K_P && m_latch) begin
                  m_vec = VEC_LO_NMI;
                  clr   = 1'b1;
               end
               if (q.size() == 0) mode = M_IDLE;
            end
         endcase
      end
      m_latch = (m_latch & ~clr) | fall;
   endtask

   function automatic logic [11:0] expected();
      logic [11:0] w;
      w = 12'h300;
      if (mode == M_HOLD || mode == M_WAIT) w = 12'hB00;
      else if (mode == M_SEQ && q.size() > 0) begin
         case (q[0])
            K_PCH:  w = 12'hC00;
            K_PCL:  w = 12'hD00;
            K_P:    w = (m_src == SRC_BRK) ? 12'hE80 : 12'hE00;
            K_VEC:  w = (m_vec == VEC_LO_RES) ? 12'hB40 :
                        (m_vec == VEC_LO_NMI) ? 12'hB20 : 12'hB10;
            K_INC:  w = 12'hB08;
            K_LOAD: w = 12'hB07;
            default: w = 12'hB00;
         endcase
      end
      return w;
   endfunction

   // ---------------- checking helpers ----------------
   task automatic check(input string tag, input logic [11:0] o, input logic [11:0] e);
      tests++;
      assert (o === e) else begin
         fails++;
         $error("FAIL %s: observed %03h expected %03h", tag, o, e);
      end
   endtask

   task automatic tick();
      @(posedge fclk);
      if (reset) model_reset();
      else model_step();
      @(negedge fclk);
      check("model", obs, expected());
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: observed timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      model_reset();
      repeat (2) @(posedge fclk);
      @(negedge fclk);
      check("reset_active", obs, 12'h300);
      reset = 1'b0;
      check("reset_state", obs, 12'h300);

      // Reset path: RESB low for 3 cycles
      resb_n = 1'b0;
      repeat (3) tick();
      check("rst_hold", obs, 12'hB00);
      resb_n = 1'b1;
      tick(); check("rst_d1", obs, 12'hB00);
      tick(); check("rst_d2", obs, 12'hB00);
      tick(); check("rst_d3", obs, 12'hB00);
      tick(); check("rst_vec", obs, 12'hB40);
      tick(); check("rst_inc", obs, 12'hB08);
      tick(); check("rst_load", obs, 12'hB07);
      tick(); check("rst_done", obs, 12'h300);

      // Unmasked IRQ
      irqb_n = 1'b0; i_flag = 1'b0; instr_boundary = 1'b1;
      tick(); check("irq_pch", obs, 12'hC00);
      instr_boundary = 1'b0; irqb_n = 1'b1; i_flag = 1'b1;
      tick(); check("irq_pcl", obs, 12'hD00);
      tick(); check("irq_p", obs, 12'hE00);
      tick(); check("irq_vec", obs, 12'hB10);
      tick(); check("irq_inc", obs, 12'hB08);
      tick(); check("irq_load", obs, 12'hB07);
      tick(); check("irq_done", obs, 12'h300);

      // Masked IRQ with BRK
      irqb_n = 1'b0; i_flag = 1'b1; brk_decoded = 1'b1; instr_boundary = 1'b1;
      tick(); check("brk_pch", obs, 12'hC00);
      instr_boundary = 1'b0; brk_decoded = 1'b0; irqb_n = 1'b1;
      tick(); check("brk_pcl", obs, 12'hD00);
      tick(); check("brk_p", obs, 12'hE80);
      tick(); check("brk_vec", obs, 12'hB10);
      repeat (3) tick();
      check("brk_done", obs, 12'h300);

      // BRK hijacked by NMI falling during PUSH_PCL
      brk_decoded = 1'b1; instr_boundary = 1'b1;
      tick();
      brk_decoded = 1'b0; instr_boundary = 1'b0;
      tick(); check("hij_pcl", obs, 12'hD00);
      nmib_n = 1'b0;
      tick(); check("hij_p", obs, 12'hE80);
      nmib_n = 1'b1;
      tick(); check("hij_vec", obs, 12'hB20);
      nmib_n = 1'b0;
      tick(); tick(); tick();
      check("hij_done", obs, 12'h300);
      nmib_n = 1'b1; instr_boundary = 1'b1;
      tick(); check("nmi2_pch", obs, 12'hC00);
      instr_boundary = 1'b0;
      tick(); tick();
      check("nmi2_p", obs, 12'hE00);
      tick(); check("nmi2_vec", obs, 12'hB20);
      tick(); tick(); tick();
      instr_boundary = 1'b1;
      tick(); check("nmi_cleared", obs, 12'h300);
      instr_boundary = 1'b0;

      // rdy stall in PUSH_PCL, then async reset during VEC_HI
      irqb_n = 1'b0; i_flag = 1'b0; instr_boundary = 1'b1;
      tick();
      instr_boundary = 1'b0; irqb_n = 1'b1; i_flag = 1'b1;
      tick();
      rdy = 1'b0;
      for (int i = 0; i < 4; i++) begin
         tick(); check("rdy_hold", obs, 12'hD00);
      end
      rdy = 1'b1;
      tick(); check("rdy_resume", obs, 12'hE00);
      tick(); check("rdy_vec", obs, 12'hB10);
      tick(); check("pre_async", obs, 12'hB08);
      reset = 1'b1;
      #1;
      check("async_rst", obs, 12'h300);
      tick();
      reset = 1'b0;

`ifdef WAI_SUPPORT_EN
      wai_decoded = 1'b1; instr_boundary = 1'b1;
      tick(); check("wai_enter", obs, 12'hB00);
      wai_decoded = 1'b0; instr_boundary = 1'b0;
      tick(); check("wai_stay", obs, 12'hB00);
      irqb_n = 1'b0; i_flag = 1'b1;
      tick(); check("wai_masked_exit", obs, 12'h300);
      irqb_n = 1'b1;
`endif

      // Randomized activity against the model
      for (int i = 0; i < 3000; i++) begin
         resb_n         = ($urandom_range(0, 79) != 0);
         if ($urandom_range(0, 11) == 0) nmib_n = ~nmib_n;
         irqb_n         = ($urandom_range(0, 3) != 0);
         i_flag         = ($urandom_range(0, 1) == 1);
         brk_decoded    = ($urandom_range(0, 3) == 0);
         instr_boundary = ($urandom_range(0, 2) == 0);
         rdy            = ($urandom_range(0, 4) != 0);
`ifdef WAI_SUPPORT_EN
         wai_decoded    = ($urandom_range(0, 5) == 0);
`endif
         tick();
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/irq_sequencer.md
Name: irq_sequencer

Overview:
- Sequences 65C02 reset, NMI, IRQ and BRK entry for the program-counter/stack datapath.
- Arbitrates the pending interrupt sources at instruction boundaries.
- Drives the stack-push cycles, then drives the PCL vector-select strobes (push_resb/push_nmib/push_irqb) and the increment_pc strobe that form vector addresses FFFA..FFFF.
- Sits between the instruction decoder and the PCL/PCH/stack-pointer registers.

Parameters:
- RESET_HOLD_MIN, 2, minimum fclk cycles resb_n must stay low before the reset sequence may start.

Ports:
- fclk  input  1  core clock; all state changes on rising edge
- reset  input  1  asynchronous, active-high reset
- resb_n  input  1  synchronised RESB pin, active low, level-sensitive
- nmib_n  input  1  synchronised NMIB pin, falling-edge-sensitive
- irqb_n  input  1  synchronised IRQB pin, active low, level-sensitive
- i_flag  input  1  current processor-status I bit
- brk_decoded  input  1  current opcode is BRK
- instr_boundary  input  1  one-cycle pulse in the last cycle of each instruction
- rdy  input  1  1 = advance; 0 = freeze all state (outputs held)
- busy  output  1  sequence in progress; decoder must not fetch
- stack_wr  output  1  stack write strobe this cycle
- stack_src  output  2  0=PCH, 1=PCL, 2=P, 3=none
- b_flag  output  1  B bit value for pushed P (1 only for BRK)
- push_resb  output  1  PCL vector select FC
- push_nmib  output  1  PCL vector select FA
- push_irqb  output  1  PCL vector select FE (IRQ and BRK)
- increment_pc  output  1  PCL increment, forms vector high address
- load_pc  output  1  load fetched vector into PCL/PCH
- set_i  output  1  set I flag
- clear_d  output  1  clear D flag (65C02)

Behaviour:
- Reset values: all outputs 0, stack_src=3, state IDLE, NMI latch cleared.
- States: IDLE, RST_HOLD, RST_D1, RST_D2, RST_D3, PUSH_PCH, PUSH_PCL, PUSH_P, VEC_LO, VEC_HI, LOAD.
- resb_n low in any state → RST_HOLD next edge, overriding everything. Stay in RST_HOLD while resb_n is low and for at least RESET_HOLD_MIN cycles.
- Reset path: RST_HOLD → RST_D1 → RST_D2 → RST_D3 → VEC_LO → VEC_HI → LOAD → IDLE. The RST_D1..D3 dummy stack cycles have stack_wr=0.
- NMI latch: set on a 1→0 transition of nmib_n, sampled every fclk. Cleared in the cycle VEC_LO is entered with NMI selected. A new edge during that cycle stays latched.
- At instr_boundary in IDLE, with rdy=1, the source is chosen by priority:
  - NMI latch set → NMI
  - else irqb_n=0 and i_flag=0 → IRQ
  - else brk_decoded → BRK
  - else remain IDLE.
- Chosen sequence: PUSH_PCH → PUSH_PCL → PUSH_P (stack_wr=1, stack_src=0/1/2) → VEC_LO → VEC_HI → LOAD → IDLE. Entry latency is one cycle after instr_boundary.
- b_flag=1 only in PUSH_P of a BRK sequence.
- Vector hijack: if the NMI latch becomes set before VEC_LO is entered during an IRQ/BRK sequence, the vector is NMI. The pushed b_flag keeps its BRK value.
- VEC_LO: exactly one of push_resb/push_nmib/push_irqb=1 for one cycle.
- VEC_HI: increment_pc=1 for one cycle.
- LOAD: load_pc=1, set_i=1, clear_d=1 for one cycle.
- busy=1 in every state except IDLE.
- rdy=0: state and outputs frozen. Edges on nmib_n are still latched.
- Async reset mid-sequence: immediate return to IDLE with all strobes 0. No partial stack write completes after reset assertion.

Optional Feature:
- Macro WAI_SUPPORT_EN.
- Defined: adds input wai_decoded (1 bit) and state WAIT.
  - wai_decoded at instr_boundary → WAIT; busy=1 in WAIT.
  - Exit on NMI latch set or irqb_n=0.
  - If irqb_n=0 and i_flag=1: return to IDLE without servicing. busy drops after one cycle.
  - Otherwise enter PUSH_PCH directly.
  - resb_n low still forces RST_HOLD.
- Not defined: no port, no state; behaviour identical to the above.

Decomposition:
- Package irq_seq_pkg holds:
  - state enum
  - stack_src encoding constants (SRC_PCH, SRC_PCL, SRC_P, SRC_NONE)
  - source enum (SRC_RST, SRC_NMI, SRC_IRQ, SRC_BRK)
  - vector-low constants 8'hFA, 8'hFC, 8'hFE for bench checking.
- One sub-module: nmi_edge_latch (edge detect plus set/clear latch with rdy-independent capture).

Test Plan:
- Reset path: hold resb_n=0 for 3 cycles, release → 3 dummy cycles with stack_wr=0, then push_resb=1, next cycle increment_pc=1, next cycle load_pc=1/set_i=1/clear_d=1; busy=0 afterwards.
- IRQ: irqb_n=0, i_flag=0, instr_boundary pulse → stack_src 0,1,2 on consecutive cycles with stack_wr=1 and b_flag=0, then push_irqb=1, then increment_pc=1, then load_pc=1.
- Masked IRQ and BRK: irqb_n=0, i_flag=1, brk_decoded=1 → BRK sequence with b_flag=1 in PUSH_P and push_irqb=1.
- NMI hijack: start BRK, drop nmib_n during PUSH_PCL → push_nmib=1 (not push_irqb) and NMI latch cleared. A second nmib_n fall in the VEC_LO cycle triggers another NMI at the next boundary.
- rdy=0 for 4 cycles in PUSH_PCL → stack_src=1 and stack_wr=1 held; the sequence resumes unchanged after rdy=1.
- Async reset asserted during VEC_HI → outputs 0 and busy=0 before the next fclk edge. With WAI_SUPPORT_EN defined: WAIT, then irqb_n=0 with i_flag=1 → IDLE with no stack_wr.
